// File: rtl/mnv3_layer_sequencer.sv
// Descriptor-driven layer sequencer: per layer fetch, weight load, issue, run, with watchdog and abort.
// Optional per-layer cycle counters enabled by defining MNV3_SEQ_PERF_COUNTERS_EN.
module mnv3_layer_sequencer #(
   parameter  int MAX_LAYERS = 32,
   parameter  int DESC_WIDTH = 64,
   parameter  int TIMEOUT_W  = 24,
   localparam int LW         = $clog2(MAX_LAYERS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_we,
   input  logic [LW-1:0]         cfg_addr,
   input  logic [DESC_WIDTH-1:0] cfg_wdata,
   input  logic [LW:0]           num_layers,
   input  logic [TIMEOUT_W-1:0]  timeout_limit,
   input  logic                  start,
   input  logic                  abort,
   output logic                  wl_req,
   output logic [DESC_WIDTH-1:0] wl_desc,
   input  logic                  wl_ack,
   output logic                  run_valid,
   input  logic                  run_ready,
   output logic [DESC_WIDTH-1:0] run_desc,
   input  logic                  run_done,
   output logic [LW-1:0]         layer_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   input  logic [LW-1:0]         perf_addr,
   output logic [31:0]           perf_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_ISSUE = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_NEXT  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERROR = 3'd7;

   localparam logic [LW:0] MAX_N = (LW+1)'(MAX_LAYERS);

   logic [2:0]            state, state_nxt;
   logic [LW-1:0]         last_idx;
   logic [TIMEOUT_W-1:0]  tlim, wd_cnt;
   logic [DESC_WIDTH-1:0] cur_desc;
   logic [DESC_WIDTH-1:0] desc_mem [MAX_LAYERS];
   logic                  error_r;
   logic [1:0]            err_code_r;
   logic                  wd_hit;
   logic                  start_ok;
   logic [LW:0]           n_eff;

   assign start_ok = (state == S_IDLE) && start && !abort;
   assign n_eff    = (num_layers > MAX_N) ? MAX_N : num_layers;
   assign wd_hit   = (tlim != '0) && (wd_cnt == tlim);

   assign wl_req    = (state == S_LOAD);
   assign run_valid = (state == S_ISSUE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign wl_desc   = cur_desc;
   assign run_desc  = cur_desc;
   assign error     = error_r;
   assign err_code  = err_code_r;

   // Descriptor storage has no reset; writes only land while idle.
   always_ff @(posedge clk) begin
      if (cfg_we && (state == S_IDLE))
         desc_mem[cfg_addr] <= cfg_wdata;
   end

   // Completion is tested before the watchdog so a same-cycle completion wins.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = (num_layers == '0) ? S_ERROR : S_FETCH;
            S_FETCH: state_nxt = desc_mem[layer_idx][0] ? S_ISSUE : S_LOAD;
            S_LOAD: begin
               if (wl_ack)      state_nxt = S_ISSUE;
               else if (wd_hit) state_nxt = S_ERROR;
            end
            S_ISSUE: begin
               if (run_ready)   state_nxt = S_RUN;
               else if (wd_hit) state_nxt = S_ERROR;
            end
            S_RUN: begin
               if (run_done)    state_nxt = S_NEXT;
               else if (wd_hit) state_nxt = S_ERROR;
            end
            S_NEXT:  state_nxt = (layer_idx == last_idx) ? S_DONE : S_FETCH;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         layer_idx  <= '0;
         last_idx   <= '0;
         tlim       <= '0;
         wd_cnt     <= '0;
         cur_desc   <= '0;
         error_r    <= 1'b0;
         err_code_r <= 2'b00;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            layer_idx  <= '0;
            last_idx   <= LW'(n_eff - (LW+1)'(1));
            tlim       <= timeout_limit;
            error_r    <= (num_layers == '0);
            err_code_r <= (num_layers == '0) ? 2'b11 : 2'b00;
         end
         if (state == S_FETCH)
            cur_desc <= desc_mem[layer_idx];
         if ((state != S_IDLE) && (state_nxt == S_ERROR)) begin
            error_r    <= 1'b1;
            err_code_r <= (state == S_LOAD) ? 2'b01 : 2'b10;
         end
         // ISSUE and RUN share one watchdog window: cleared only on ISSUE entry.
         if (((state_nxt == S_LOAD) && (state != S_LOAD)) ||
             ((state_nxt == S_ISSUE) && (state != S_ISSUE)))
            wd_cnt <= '0;
         else if ((state == S_LOAD) || (state == S_ISSUE) || (state == S_RUN))
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
         if ((state == S_NEXT) && (state_nxt == S_FETCH))
            layer_idx <= layer_idx + LW'(1);
      end
   end

`ifdef MNV3_SEQ_PERF_COUNTERS_EN
   logic [31:0] perf_cnt [MAX_LAYERS];
   logic [31:0] perf_q;
   logic        in_layer;

   assign in_layer  = (state == S_FETCH) || (state == S_LOAD) || (state == S_ISSUE) ||
                      (state == S_RUN) || (state == S_NEXT);
   assign perf_data = perf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < MAX_LAYERS; i++)
            perf_cnt[i[LW-1:0]] <= '0;
         perf_q <= '0;
      end else begin
         if (start_ok) begin
            for (int unsigned i = 0; i < MAX_LAYERS; i++)
               perf_cnt[i[LW-1:0]] <= '0;
         end else if (in_layer && (perf_cnt[layer_idx] != '1)) begin
            perf_cnt[layer_idx] <= perf_cnt[layer_idx] + 32'd1;
         end
         perf_q <= perf_cnt[perf_addr];
      end
   end
`else
   logic unused_perf_addr;
   assign unused_perf_addr = ^perf_addr;
   assign perf_data        = '0;
`endif

endmodule

// File: tb/tb_mnv3_layer_sequencer.sv
// Directed bench for mnv3_layer_sequencer: vector table of whole sequences plus hand-written corner cases.
module tb_mnv3_layer_sequencer;
   localparam int ML = 4;
   localparam int DW = 16;
   localparam int TW = 8;
   localparam int LW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [LW-1:0] cfg_addr = '0;
   logic [DW-1:0] cfg_wdata = '0;
   logic [LW:0]   num_layers = '0;
   logic [TW-1:0] timeout_limit = '0;
   logic          start = 1'b0, abort = 1'b0;
   logic          wl_req, wl_ack = 1'b0;
   logic [DW-1:0] wl_desc, run_desc;
   logic          run_valid, run_ready = 1'b0, run_done = 1'b0;
   logic [LW-1:0] layer_idx;
   logic [LW-1:0] perf_addr = '0;
   logic          busy, done, error;
   logic [1:0]    err_code;
   logic [31:0]   perf_data;

   mnv3_layer_sequencer #(.MAX_LAYERS(ML), .DESC_WIDTH(DW), .TIMEOUT_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .num_layers(num_layers), .timeout_limit(timeout_limit), .start(start), .abort(abort),
      .wl_req(wl_req), .wl_desc(wl_desc), .wl_ack(wl_ack), .run_valid(run_valid),
      .run_ready(run_ready), .run_desc(run_desc), .run_done(run_done), .layer_idx(layer_idx),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .perf_addr(perf_addr), .perf_data(perf_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] n;
      logic [7:0] tlim;
      logic [3:0] skip;
      int         ack, rdy, dn;
      bit         no_ack, no_done;
      int         e_wl, e_wl_cyc, e_iss, e_done;
      logic       e_err;
      logic [1:0] e_code;
   } vec_t;

   int            checks = 0;
   int            failures = 0;
   logic [DW-1:0] model [ML];
   int            perf_exp [ML];
   vec_t          vecs [11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic write_table(input logic [3:0] mask);
      for (int i = 0; i < ML; i++) begin
         logic [DW-1:0] d;
         d = 16'hC3A0 + DW'(i) * 16'h1102;
         d[0] = mask[i];
         model[i] = d;
         @(negedge clk);
         cfg_we = 1'b1; cfg_addr = LW'(i); cfg_wdata = d;
      end
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Starts a sequence and plays memory controller and engine until busy falls.
   task automatic run_vec(input vec_t v, input int id);
      int obs, wl_cnt, rv_cnt, rd_cnt, exp_layer, fetch_obs;
      int n_wl, n_wl_cyc, n_iss, n_done;
      bit prev_wl, prev_rv, in_run, fin;
      logic [DW-1:0] held;
      string p;
      p = $sformatf("v%0d", id);
      obs = 0; wl_cnt = 0; rv_cnt = 0; rd_cnt = 0; exp_layer = 0; fetch_obs = 0;
      n_wl = 0; n_wl_cyc = 0; n_iss = 0; n_done = 0;
      prev_wl = 0; prev_rv = 0; in_run = 0; fin = 0; held = '0;
      @(negedge clk);
      num_layers = v.n; timeout_limit = v.tlim; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!fin && obs < 400) begin
         if (obs == 0 && v.n != 0) begin
            chk({p, "_busy0"}, busy, 1);
            chk({p, "_wlreq0"}, wl_req, 0);
            chk({p, "_errclr"}, error, 0);
         end
         if (obs == 1 && v.n != 0) chk({p, "_wlreq1"}, wl_req, !v.skip[0]);
         if (done) n_done++;
         if (!busy) begin
            fin = 1;
         end else begin
            wl_ack = 1'b0; run_ready = 1'b0; run_done = 1'b0;
            if (in_run) begin
               if (!v.no_done && rd_cnt == v.dn) begin
                  run_done = 1'b1; in_run = 0;
                  perf_exp[exp_layer[1:0]] = obs - fetch_obs + 2;
                  fetch_obs = obs + 2;
                  exp_layer++;
               end else begin
                  rd_cnt++;
               end
            end
            if (wl_req) begin
               if (!prev_wl) begin
                  n_wl++; wl_cnt = 0;
                  chk({p, "_wl_idx"}, layer_idx, exp_layer);
                  chk({p, "_wl_desc"}, wl_desc, model[exp_layer[1:0]]);
               end else begin
                  wl_cnt++;
               end
               n_wl_cyc++;
               if (!v.no_ack && wl_cnt == v.ack) wl_ack = 1'b1;
            end
            if (run_valid) begin
               if (!prev_rv) begin
                  n_iss++; rv_cnt = 0; held = run_desc;
                  chk({p, "_rv_idx"}, layer_idx, exp_layer);
                  chk({p, "_rv_desc"}, run_desc, model[exp_layer[1:0]]);
               end else begin
                  rv_cnt++;
                  chk({p, "_rv_stable"}, run_desc, held);
               end
               if (rv_cnt >= v.rdy) begin
                  run_ready = 1'b1; in_run = 1; rd_cnt = 0;
               end
            end
            prev_wl = wl_req; prev_rv = run_valid;
            @(negedge clk);
            obs++;
         end
      end
      if (!fin) begin
         chk({p, "_cycle_budget_busy"}, busy, 0);
         wl_ack = 1'b0; run_ready = 1'b0; run_done = 1'b0;
         abort = 1'b1; @(negedge clk); abort = 1'b0;
      end
      chk({p, "_n_wlreq"}, n_wl, v.e_wl);
      chk({p, "_wlreq_cycles"}, n_wl_cyc, v.e_wl_cyc);
      chk({p, "_n_issue"}, n_iss, v.e_iss);
      chk({p, "_n_done"}, n_done, v.e_done);
      chk({p, "_error"}, error, v.e_err);
      chk({p, "_err_code"}, err_code, v.e_code);
   endtask

   task automatic check_perf();
      for (int a = 0; a < 3; a++) begin
         @(negedge clk);
         perf_addr = LW'(a);
         @(negedge clk);
`ifdef MNV3_SEQ_PERF_COUNTERS_EN
         chk($sformatf("perf%0d", a), perf_data, perf_exp[a]);
         if (a == 0) chk("perf0_hand", perf_data, 20);
`else
         chk($sformatf("perf%0d_tied", a), perf_data, 0);
`endif
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1);
   end

   initial begin
      vec_t hv;
      int   k;
      bit   seen;
      //               n     tlim   skip    ack rdy dn na nd  wl cyc iss dn err  code
      vecs[0]  = '{3'd3, 8'd0,  4'b0000, 5, 0, 10, 0, 0, 3, 18, 3, 1, 1'b0, 2'b00};
      vecs[1]  = '{3'd2, 8'd0,  4'b0010, 5, 0, 10, 0, 0, 1, 6,  2, 1, 1'b0, 2'b00};
      vecs[2]  = '{3'd1, 8'd20, 4'b0000, 0, 0, 0,  1, 0, 1, 21, 0, 0, 1'b1, 2'b01};
      vecs[3]  = '{3'd0, 8'd0,  4'b0000, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1'b1, 2'b11};
      vecs[4]  = '{3'd2, 8'd8,  4'b0000, 0, 0, 0,  0, 1, 1, 1,  1, 0, 1'b1, 2'b10};
      vecs[5]  = '{3'd7, 8'd0,  4'b0000, 1, 0, 2,  0, 0, 4, 8,  4, 1, 1'b0, 2'b00};
      vecs[6]  = '{3'd4, 8'd0,  4'b1111, 0, 0, 0,  0, 0, 0, 0,  4, 1, 1'b0, 2'b00};
      vecs[7]  = '{3'd1, 8'd5,  4'b0000, 5, 0, 4,  0, 0, 1, 6,  1, 1, 1'b0, 2'b00};
      vecs[8]  = '{3'd1, 8'd5,  4'b0000, 6, 0, 0,  0, 0, 1, 6,  0, 0, 1'b1, 2'b01};
      vecs[9]  = '{3'd2, 8'd0,  4'b0000, 2, 6, 3,  0, 0, 2, 6,  2, 1, 1'b0, 2'b00};
      vecs[10] = '{3'd1, 8'd5,  4'b0000, 0, 0, 5,  0, 0, 1, 1,  1, 0, 1'b1, 2'b10};

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_wl_req", wl_req, 0);
      chk("rst_run_valid", run_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_layer_idx", layer_idx, 0);
      chk("rst_wl_desc", wl_desc, 0);
      chk("rst_run_desc", run_desc, 0);
      chk("rst_perf_data", perf_data, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      for (int i = 0; i < 11; i++) begin
         write_table(vecs[i].skip);
         run_vec(vecs[i], i);
         if (i == 0) check_perf();
      end

      // Abort during RUN, with a blocked table write and a stray start while busy.
      write_table(4'b0000);
      @(negedge clk);
      num_layers = 3'd2; timeout_limit = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (k = 0; k < 10 && !wl_req; k++) @(negedge clk);
      chk("ab_wl_seen", wl_req, 1);
      wl_ack = 1'b1; @(negedge clk); wl_ack = 1'b0;
      for (k = 0; k < 10 && !run_valid; k++) @(negedge clk);
      chk("ab_rv_seen", run_valid, 1);
      run_ready = 1'b1; @(negedge clk); run_ready = 1'b0;
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'hDEAD; start = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b0;
      chk("ab_busy_in_run", busy, 1);
      chk("ab_idx_in_run", layer_idx, 0);
      abort = 1'b1; @(negedge clk); abort = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_wl_req", wl_req, 0);
      chk("ab_run_valid", run_valid, 0);
      chk("ab_done", done, 0);
      chk("ab_error", error, 0);
      chk("ab_err_code", err_code, 0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      chk("ab_quiet", seen, 0);
      hv = '{3'd2, 8'd0, 4'b0000, 0, 0, 1, 0, 0, 2, 2, 2, 1, 1'b0, 2'b00};
      run_vec(hv, 90);

      // start and abort together while idle.
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", busy, 0);
      @(negedge clk);
      chk("sa_busy2", busy, 0);
      chk("sa_wl_req", wl_req, 0);

      // Reset asserted mid-sequence.
      @(negedge clk);
      num_layers = 3'd3; timeout_limit = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("mr_wl_req_before", wl_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_wl_req", wl_req, 0);
      chk("mr_wl_desc", wl_desc, 0);
      chk("mr_layer_idx", layer_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
